// File: rtl/swap_arbiter_if.sv
// Request/grant bundle between the swap requesters, the arbiter and the
// register-file datapath (read/write addresses, write enables, data mux select).
interface swap_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 3
);
    // Handshake: a requester raises req[i] with stable addresses and keeps both
    // until it samples done[i]; done[i] is a one-cycle pulse; addresses are
    // captured at grant, so req may fall mid-swap without aborting it.
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr_a;
    logic [NREQ*ADDR_W-1:0] req_addr_b;
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        done;
    logic                   busy;
    logic [ADDR_W-1:0]      rf_raddr;
    logic [ADDR_W-1:0]      rf_waddr;
    logic                   rf_we;
    logic                   tmp_we;
    logic                   wdata_sel;

    modport master (
        output req, req_addr_a, req_addr_b,
        input  grant, done, busy, rf_raddr, rf_waddr, rf_we, tmp_we, wdata_sel
    );

    modport slave (
        input  req, req_addr_a, req_addr_b,
        output grant, done, busy, rf_raddr, rf_waddr, rf_we, tmp_we, wdata_sel
    );
endinterface

// File: rtl/swap_arbiter.sv
// Round-robin arbiter that serialises register-file swap requests and sequences
// the tmp<=RF[a], RF[a]<=RF[b], RF[b]<=tmp datapath for the granted requester.
module swap_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    swap_arbiter_if.slave    bus,
    output logic [2:0]       state_dbg
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MOVE  = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    win_idx_q;
    logic [ADDR_W-1:0]   addr_a_q, addr_b_q;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [ADDR_W-1:0]   pick_a, pick_b;
    logic [NREQ-1:0]     win_onehot;

    // Search starts at rr_ptr and wraps at NREQ-1, so non-power-of-2 counts work.
    always_comb begin : arbitrate
        logic [IDX_W-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = rr_ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
            cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
        end
    end

    assign pick_a = bus.req_addr_a[pick_idx*ADDR_W +: ADDR_W];
    assign pick_b = bus.req_addr_b[pick_idx*ADDR_W +: ADDR_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            win_idx_q <= '0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_found) begin
                win_idx_q <= pick_idx;
                addr_a_q  <= pick_a;
                addr_b_q  <= pick_b;
                rr_ptr_q  <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
            end
        end
    end

    // A same-address swap skips the datapath entirely and only reports done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = (pick_a != pick_b) ? LOAD : DONE;
                end
            end
            LOAD:    state_d = MOVE;
            MOVE:    state_d = STORE;
            STORE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        win_onehot            = '0;
        win_onehot[win_idx_q] = 1'b1;
    end

    always_comb begin
        bus.grant     = '0;
        bus.done      = '0;
        bus.busy      = 1'b0;
        bus.rf_raddr  = '0;
        bus.rf_waddr  = '0;
        bus.rf_we     = 1'b0;
        bus.tmp_we    = 1'b0;
        bus.wdata_sel = 1'b0;
        case (state_q)
            LOAD: begin
                bus.grant    = win_onehot;
                bus.busy     = 1'b1;
                bus.rf_raddr = addr_a_q;
                bus.tmp_we   = 1'b1;
            end
            MOVE: begin
                bus.grant    = win_onehot;
                bus.busy     = 1'b1;
                bus.rf_raddr = addr_b_q;
                bus.rf_waddr = addr_a_q;
                bus.rf_we    = 1'b1;
            end
            STORE: begin
                bus.grant     = win_onehot;
                bus.busy      = 1'b1;
                bus.rf_waddr  = addr_b_q;
                bus.rf_we     = 1'b1;
                bus.wdata_sel = 1'b1;
            end
            DONE: begin
                bus.grant = win_onehot;
                bus.done  = win_onehot;
                bus.busy  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state_dbg = state_q;
endmodule
